// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity mode constants and frame-length helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD = 2;
  function automatic int frame_ticks(input int data_w, input int parity, input int stop_bits, input int osr);
    return (1 + data_w + (parity != PAR_NONE ? 1 : 0) + stop_bits) * osr;
  endfunction
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: synchronous FIFO (push/pop, full/empty, zero when empty head) using an extra pointer wrap bit
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver; sync'd line, mid-bit FSM, parity/stop checks, sticky flags, word FIFO
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PARITY = PAR_EVEN,
  parameter int STOP_BITS = 1,
  parameter int OSR = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              data_in,
  input  logic              err_clr,
  input  logic              ready,
  output logic [DATA_W-1:0] data_bus,
  output logic              valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OSR - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic PAR_INIT = PARITY == PAR_ODD;
  rx_state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic par_q, par_d, bad_q, bad_d;
  logic parity_err_q, frame_err_q, overrun_q;
  logic line, sample, push, pop, full, empty, perr_set, ferr_set, ovr_set;
  assign line = sync_q[1];
  assign sample = enable && tick_q == TICK_END;
  assign valid = !empty;
  assign pop = valid && ready;
  assign parity_err = parity_err_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        S_IDLE:      state_d = line ? S_IDLE : S_START;
        S_START:     state_d = tick_q != TICK_MID ? S_START : line ? S_IDLE : S_DATA;
        S_DATA:      state_d = (!sample || bit_q != BIT_LAST) ? S_DATA : (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
        S_PARITY:    state_d = sample ? S_STOP : S_PARITY;
        S_STOP:      state_d = !sample ? S_STOP : !line ? S_WAIT_IDLE : (bit_q == STOP_LAST) ? S_IDLE : S_STOP;
        S_WAIT_IDLE: state_d = line ? S_IDLE : S_WAIT_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end
  always_comb begin
    busy = state_q != S_IDLE;
    perr_set = sample && state_q == S_PARITY && line != par_q;
    ferr_set = sample && state_q == S_STOP && !line;
    push = sample && state_q == S_STOP && line && bit_q == STOP_LAST && !bad_q;
    ovr_set = push && full && !pop;
  end
  always_comb begin
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    bad_d = bad_q;
    if (enable) begin
      tick_d = (state_q == S_IDLE || state_d != state_q || tick_q == TICK_END) ? '0 : tick_q + 1'b1;
      bit_d = (state_q == S_IDLE) ? '0 : !sample ? bit_q : (state_d != state_q) ? '0 : bit_q + 1'b1;
      par_d = (state_q == S_IDLE) ? PAR_INIT : (sample && state_q == S_DATA) ? par_q ^ line : par_q;
      bad_d = (state_q == S_IDLE) ? 1'b0 : (sample && state_q == S_PARITY) ? line != par_q : bad_q;
      if (sample && state_q == S_DATA) shift_d = {line, shift_q[DATA_W-1:1]};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      bad_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], data_in};
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      bad_q <= bad_d;
      parity_err_q <= perr_set || (parity_err_q && !err_clr);
      frame_err_q <= ferr_set || (frame_err_q && !err_clr);
      overrun_q <= ovr_set || (overrun_q && !err_clr);
    end
  end
  rx_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(shift_q),
    .rdata(data_bus),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for two receiver configurations (8E1 and 7O2, OSR 16, enable every clock)
module tb_uart_rx_param;
  import uart_pkg::*;
  localparam int FRAME_A = frame_ticks(8, PAR_EVEN, 1, 16);
  localparam int FRAME_B = frame_ticks(7, PAR_ODD, 2, 16);
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic din_a = 1'b1, clr_a = 1'b0, rdy_a = 1'b0;
  logic din_b = 1'b1, clr_b = 1'b0, rdy_b = 1'b0;
  logic [7:0] bus_a;
  logic [6:0] bus_b;
  logic valid_a, busy_a, perr_a, ferr_a, ovr_a;
  logic valid_b, busy_b, perr_b, ferr_b, ovr_b;
  logic [7:0] exp_a[$];
  logic [6:0] exp_b[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_param u_a (
    .clk(clk), .rst(rst), .enable(en), .data_in(din_a), .err_clr(clr_a), .ready(rdy_a),
    .data_bus(bus_a), .valid(valid_a), .busy(busy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  uart_rx_param #(.DATA_W(7), .PARITY(PAR_ODD), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .enable(en), .data_in(din_b), .err_clr(clr_b), .ready(rdy_b),
    .data_bus(bus_b), .valid(valid_b), .busy(busy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  task automatic bit_a(input logic b, input int n);
    din_a = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_b(input logic b, input int n);
    din_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic head_a(input logic [7:0] w, input logic p);
    bit_a(1'b0, 16);
    for (int i = 0; i < 8; i++) bit_a(w[i], 16);
    bit_a(p, 16);
  endtask

  task automatic frame_a(input logic [7:0] w, input logic p, input logic s);
    head_a(w, p);
    bit_a(s, FRAME_A - 160);
  endtask

  task automatic frame_b(input logic [6:0] w, input logic p);
    bit_b(1'b0, 16);
    for (int i = 0; i < 7; i++) bit_b(w[i], 16);
    bit_b(p, 16);
    bit_b(1'b1, FRAME_B - 144);
  endtask

  task automatic drain_a(input string name);
    int n;
    logic [7:0] e;
    n = 0;
    rdy_a = 1'b1;
    while (valid_a && n < 16) begin
      tests++;
      if (exp_a.size() == 0) begin
        fails++;
        $display("FAIL %s_extra got %h want no word", name, bus_a);
      end else begin
        e = exp_a.pop_front();
        if (bus_a !== e) begin
          fails++;
          $display("FAIL %s_data got %h want %h", name, bus_a, e);
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    rdy_a = 1'b0;
    tests++;
    if (exp_a.size() != 0 || valid_a !== 1'b0) begin
      fails++;
      $display("FAIL %s_empty got %0d left valid %b want 0 left valid 0", name, exp_a.size(), valid_a);
      exp_a.delete();
    end
  endtask

  task automatic drain_b(input string name);
    int n;
    logic [6:0] e;
    n = 0;
    rdy_b = 1'b1;
    while (valid_b && n < 16) begin
      tests++;
      if (exp_b.size() == 0) begin
        fails++;
        $display("FAIL %s_extra got %h want no word", name, bus_b);
      end else begin
        e = exp_b.pop_front();
        if (bus_b !== e) begin
          fails++;
          $display("FAIL %s_data got %h want %h", name, bus_b, e);
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    rdy_b = 1'b0;
    tests++;
    if (exp_b.size() != 0 || valid_b !== 1'b0) begin
      fails++;
      $display("FAIL %s_empty got %0d left valid %b want 0 left valid 0", name, exp_b.size(), valid_b);
      exp_b.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({valid_a, busy_a, perr_a, ferr_a, ovr_a, bus_a} !== 13'b0) begin
      fails++;
      $display("FAIL reset_a got %b want 0", {valid_a, busy_a, perr_a, ferr_a, ovr_a, bus_a});
    end
    tests++;
    if ({valid_b, busy_b, perr_b, ferr_b, ovr_b, bus_b} !== 12'b0) begin
      fails++;
      $display("FAIL reset_b got %b want 0", {valid_b, busy_b, perr_b, ferr_b, ovr_b, bus_b});
    end
    bit_a(1'b1, 8);
  endtask

  task automatic test_good;
    head_a(8'hA5, 1'b0);
    exp_a.push_back(8'hA5);
    bit_a(1'b1, 10);
    tests++;
    if (valid_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL good_before_stop got valid %b busy %b want valid 0 busy 1", valid_a, busy_a);
    end
    bit_a(1'b1, 1);
    tests++;
    if (valid_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL good_after_stop got valid %b busy %b want valid 1 busy 0", valid_a, busy_a);
    end
    tests++;
    if (bus_a !== exp_a[0]) begin
      fails++;
      $display("FAIL good_head got %h want %h", bus_a, exp_a[0]);
    end
    bit_a(1'b1, 5);
    tests++;
    if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin
      fails++;
      $display("FAIL good_flags got %b want 000", {perr_a, ferr_a, ovr_a});
    end
    drain_a("good");
  endtask

  task automatic test_glitch;
    bit_a(1'b0, 4);
    tests++;
    if (busy_a !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy_high got %b want 1", busy_a);
    end
    bit_a(1'b1, 12);
    tests++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy_low got %b want 0", busy_a);
    end
    bit_a(1'b1, 200);
    tests++;
    if ({valid_a, perr_a, ferr_a, ovr_a} !== 4'b0000) begin
      fails++;
      $display("FAIL glitch_quiet got %b want 0000", {valid_a, perr_a, ferr_a, ovr_a});
    end
  endtask

  task automatic test_parity;
    logic [7:0] w;
    w = 8'hA5;
    bit_a(1'b0, 16);
    for (int i = 0; i < 8; i++) bit_a(w[i], 16);
    bit_a(1'b1, 10);
    clr_a = 1'b1;
    bit_a(1'b1, 1);
    clr_a = 1'b0;
    tests++;
    if (perr_a !== 1'b1) begin
      fails++;
      $display("FAIL parity_set_wins got %b want 1", perr_a);
    end
    bit_a(1'b1, 5);
    bit_a(1'b1, 16);
    bit_a(1'b1, 4);
    tests++;
    if ({valid_a, perr_a, ferr_a} !== 3'b010) begin
      fails++;
      $display("FAIL parity_result got %b want 010", {valid_a, perr_a, ferr_a});
    end
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    tests++;
    if (perr_a !== 1'b0) begin
      fails++;
      $display("FAIL parity_clear got %b want 0", perr_a);
    end
  endtask

  task automatic test_frame;
    head_a(8'h3C, 1'b0);
    bit_a(1'b0, 48);
    tests++;
    if ({ferr_a, busy_a, valid_a} !== 3'b110) begin
      fails++;
      $display("FAIL frame_wait got %b want 110", {ferr_a, busy_a, valid_a});
    end
    bit_a(1'b1, 200);
    tests++;
    if ({busy_a, valid_a, perr_a} !== 3'b000) begin
      fails++;
      $display("FAIL frame_no_second got %b want 000", {busy_a, valid_a, perr_a});
    end
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    tests++;
    if (ferr_a !== 1'b0) begin
      fails++;
      $display("FAIL frame_clear got %b want 0", ferr_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w;
    for (int i = 1; i <= 5; i++) begin
      w = 8'(i);
      frame_a(w, ^w, 1'b1);
      if (i <= 4) exp_a.push_back(w);
    end
    tests++;
    if ({ovr_a, valid_a} !== 2'b11) begin
      fails++;
      $display("FAIL overrun_set got %b want 11", {ovr_a, valid_a});
    end
    tests++;
    if (bus_a !== exp_a[0]) begin
      fails++;
      $display("FAIL overrun_head_stable got %h want %h", bus_a, exp_a[0]);
    end
    drain_a("overrun");
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w = 8'(i);
      frame_a(w, ^w, 1'b1);
      exp_a.push_back(w);
    end
    w = 8'h05;
    head_a(w, ^w);
    bit_a(1'b1, 10);
    rdy_a = 1'b1;
    tests++;
    if (bus_a !== exp_a[0]) begin
      fails++;
      $display("FAIL simul_pop_data got %h want %h", bus_a, exp_a[0]);
    end
    void'(exp_a.pop_front());
    bit_a(1'b1, 1);
    rdy_a = 1'b0;
    exp_a.push_back(w);
    bit_a(1'b1, 5);
    tests++;
    if (ovr_a !== 1'b0) begin
      fails++;
      $display("FAIL simul_no_overrun got %b want 0", ovr_a);
    end
    drain_a("simul");
  endtask

  task automatic test_cfg_b;
    frame_b(7'h3C, 1'b1);
    exp_b.push_back(7'h3C);
    tests++;
    if (valid_b !== 1'b1 || bus_b !== exp_b[0]) begin
      fails++;
      $display("FAIL b_good got valid %b data %h want valid 1 data %h", valid_b, bus_b, exp_b[0]);
    end
    frame_b(7'h3C, 1'b0);
    tests++;
    if ({perr_b, ferr_b, valid_b} !== 3'b101 || bus_b !== exp_b[0]) begin
      fails++;
      $display("FAIL b_bad_parity got %b data %h want 101 data %h", {perr_b, ferr_b, valid_b}, bus_b, exp_b[0]);
    end
    bit_b(1'b0, 16);
    bit_b(1'b0, 16);
    bit_b(1'b1, 16);
    bit_b(1'b1, 8);
    tests++;
    if (busy_b !== 1'b1) begin
      fails++;
      $display("FAIL b_mid_frame_busy got %b want 1", busy_b);
    end
    din_b = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_b.delete();
    tests++;
    if ({valid_b, busy_b, perr_b, ferr_b, ovr_b, bus_b} !== 12'b0) begin
      fails++;
      $display("FAIL b_mid_reset got %b want 0", {valid_b, busy_b, perr_b, ferr_b, ovr_b, bus_b});
    end
    bit_b(1'b1, 200);
    tests++;
    if ({valid_b, busy_b} !== 2'b00) begin
      fails++;
      $display("FAIL b_after_reset_idle got %b want 00", {valid_b, busy_b});
    end
    frame_b(7'h15, 1'b0);
    exp_b.push_back(7'h15);
    drain_b("b_post_reset");
  endtask

  initial begin
    test_reset();
    test_good();
    test_glitch();
    test_parity();
    test_frame();
    test_back_to_back();
    test_cfg_b();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
